sensor_acq_buffer: RTL and testbench

//  Acquisition front-end between the raw off-chip sensor port and the sensor AXI

---
 rtl/sensor_acq_buffer.sv | 169 ++++++++++++++++
 tb/tb_sensor_acq_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_acq_buffer.sv
// sensor_acq_buffer: periodic req/ack sample acquisition from the raw sensor
// port. Samples are held in a small FIFO and handed to the AXI wrapper as
// single-cycle sensor_ready/sensor_out strobes. A request that is never
// acknowledged raises a sticky timeout flag. Samples that arrive while the
// FIFO is full are discarded and counted in a saturating drop counter.
module sensor_acq_buffer #(
  parameter int DATA_W     = 32,
  parameter int PERIOD     = 16,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor_en,
  input  logic              sensor_hold,
  output logic              sensor_ready,
  output logic [DATA_W-1:0] sensor_out,
  output logic              raw_req,
  input  logic              raw_ack,
  input  logic [DATA_W-1:0] raw_data,
  output logic              timeout_err,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [PW-1:0] WAIT_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] WAIT_ONE  = PW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic [PW-1:0]     wait_cnt_r;
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];

  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic wr_ok_s;
  logic drop_s;

  // FIFO status and the push/pop/drop decisions for the current cycle
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
              (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // raw_ack only means something while a request is outstanding
    push_s  = sensor_en && (state_r == ST_REQ) && raw_ack;
    pop_s   = sensor_en && !sensor_hold && !empty_s;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    wr_ok_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
  end

  // Request sequencer: IDLE -> REQ -> WAIT -> REQ, with timeout and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      raw_req     <= 1'b0;
      tmo_cnt_r   <= {TW{1'b0}};
      wait_cnt_r  <= {PW{1'b0}};
      timeout_err <= 1'b0;
    end else if (!sensor_en) begin
      state_r     <= ST_IDLE;
      raw_req     <= 1'b0;
      tmo_cnt_r   <= {TW{1'b0}};
      wait_cnt_r  <= {PW{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // first request goes out immediately after enable
          state_r   <= ST_REQ;
          raw_req   <= 1'b1;
          tmo_cnt_r <= {TW{1'b0}};
        end
        ST_REQ: begin
          if (raw_ack) begin
            // an ack on the final timeout cycle still counts as success
            state_r    <= ST_WAIT;
            raw_req    <= 1'b0;
            wait_cnt_r <= {PW{1'b0}};
          end else if (tmo_cnt_r == TMO_LAST) begin
            timeout_err <= 1'b1;
            state_r     <= ST_WAIT;
            raw_req     <= 1'b0;
            wait_cnt_r  <= {PW{1'b0}};
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r   <= ST_REQ;
            raw_req   <= 1'b1;
            tmo_cnt_r <= {TW{1'b0}};
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          raw_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and saturating drop counter; disable flushes both
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
      drop_cnt <= 8'd0;
    end else if (!sensor_en) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
      drop_cnt <= 8'd0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Sample storage; contents are only meaningful between the pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= raw_data;
    end
  end

  // Output strobe register; sensor_out keeps the last delivered sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sensor_ready <= 1'b0;
      sensor_out   <= {DATA_W{1'b0}};
    end else begin
      sensor_ready <= pop_s;
      if (pop_s) begin
        sensor_out <= mem_r[rd_ptr_r[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_sensor_acq_buffer.sv
// Bench for sensor_acq_buffer: randomized sensor responses, a queue-based
// reference model of buffering/dropping, a scoreboard of expected strobes
// (value and cycle) and timestamp checks on the request waveform.
module tb_sensor_acq_buffer;

  localparam int DATA_W  = 32;
  localparam int PERIOD  = 4;
  localparam int TIMEOUT = 10;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sensor_en = 1'b0;
  logic              sensor_hold = 1'b0;
  logic              raw_ack = 1'b0;
  logic [DATA_W-1:0] raw_data = '0;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic              raw_req;
  logic              timeout_err;
  logic [7:0]        drop_cnt;

  sensor_acq_buffer #(
    .DATA_W(DATA_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sensor_en(sensor_en), .sensor_hold(sensor_hold),
    .sensor_ready(sensor_ready), .sensor_out(sensor_out), .raw_req(raw_req),
    .raw_ack(raw_ack), .raw_data(raw_data), .timeout_err(timeout_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  logic [31:0] mq[$];        // samples buffered in the model FIFO
  logic [31:0] exp_q[$];     // expected strobe values
  int          exp_cyc_q[$]; // cycle in which each strobe must be visible
  int          m_drop   = 0;
  bit          m_tmo    = 1'b0;
  int          last_dis = 0;
  int          en_first = -1;
  int          ack_cyc  = -1;
  bit          prev_dis = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, evaluated on every active edge from the inputs alone
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst || !sensor_en) begin
      mq.delete();
      m_drop   = 0;
      m_tmo    = 1'b0;
      last_dis = cyc;
      prev_dis = 1'b1;
    end else begin
      if (prev_dis) begin
        en_first = cyc;
        prev_dis = 1'b0;
      end
      if (!sensor_hold && mq.size() > 0) begin
        exp_q.push_back(mq.pop_front());
        exp_cyc_q.push_back(cyc);
      end
      if (raw_ack) begin
        ack_cyc = cyc;
        if (mq.size() < DEPTH) mq.push_back(raw_data);
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  // Asynchronous reset empties the model at once
  initial forever begin
    @(negedge rst);
    mq.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    m_drop   = 0;
    m_tmo    = 1'b0;
    last_dis = cyc;
    prev_dis = 1'b1;
  end

  // Monitor: strobes against the scoreboard, request timing, status outputs
  int   r_cyc = 0;
  int   f_cyc = -1;
  logic prev_req = 1'b0;
  initial forever begin
    @(negedge clk);
    if (sensor_ready) begin
      chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("strobe_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        chk("strobe_data", sensor_out, exp_q.pop_front());
      end
    end
    if (raw_req && !prev_req) begin
      if (f_cyc > last_dis) chk("req_gap", 32'(cyc - f_cyc), 32'(PERIOD));
      else                  chk("req_first", 32'(cyc), 32'(en_first));
      r_cyc = cyc;
    end
    if (!raw_req && prev_req) begin
      if (ack_cyc != cyc && last_dis < cyc) begin
        chk("req_timeout_len", 32'(cyc - r_cyc), 32'(TIMEOUT));
        m_tmo = 1'b1;
      end
      f_cyc = cyc;
    end
    if (ack_cyc == cyc) chk("req_drop_on_ack", 32'(raw_req), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    prev_req = raw_req;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_level(input logic lvl, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < PERIOD + TIMEOUT + 8; i++) begin
      if (raw_req == lvl) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Act as the raw sensor for one request: ack after d cycles, or never
  task automatic serve(input int d, input bit no_ack, input bit rel_hold, input logic [31:0] val);
    wait_level(1'b1, "req_seen");
    if (raw_req) begin
      if (no_ack) begin
        wait_level(1'b0, "req_released");
      end else begin
        for (int i = 0; i < d; i++) tick();
        raw_ack  = 1'b1;
        raw_data = val;
        if (rel_hold) sensor_hold = 1'b0;
        tick();
        raw_ack = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_raw_req"}, 32'(raw_req), 32'd0);
    chk({tag, "_sensor_ready"}, 32'(sensor_ready), 32'd0);
    chk({tag, "_sensor_out"}, sensor_out, 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    rst = 1'b1;
    tick();

    // basic acquisition, including the ack-on-last-timeout-cycle boundary
    sensor_en = 1'b1;
    serve(3, 1'b0, 1'b0, 32'h12345678);
    for (int i = 0; i < 8; i++) serve($urandom_range(0, TIMEOUT - 1), 1'b0, 1'b0, $urandom());
    serve(TIMEOUT - 1, 1'b0, 1'b0, $urandom());
    serve(0, 1'b0, 1'b0, $urandom());

    // timeouts; error stays set across later successful requests
    serve(0, 1'b1, 1'b0, 32'd0);
    serve(2, 1'b0, 1'b0, $urandom());
    serve(0, 1'b1, 1'b0, 32'd0);
    serve(0, 1'b0, 1'b0, $urandom());
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // overflow while held: 6 samples into 4 entries
    repeat (3) tick();
    sensor_hold = 1'b1;
    for (int i = 0; i < 6; i++) serve(0, 1'b0, 1'b0, 32'(i + 1));
    chk("drop_after_overflow", 32'(drop_cnt), 32'd2);
    sensor_hold = 1'b0;
    repeat (8) tick();

    // hold released on the same edge as an ack into a full FIFO
    sensor_hold = 1'b1;
    for (int i = 0; i < 4; i++) serve($urandom_range(0, 3), 1'b0, 1'b0, $urandom());
    serve(1, 1'b0, 1'b1, $urandom());
    repeat (10) tick();
    chk("drop_unchanged", 32'(drop_cnt), 32'd2);

    // disable in the middle of a request with buffered words
    sensor_hold = 1'b1;
    for (int i = 0; i < 3; i++) serve(0, 1'b0, 1'b0, $urandom());
    wait_level(1'b1, "req_before_disable");
    sensor_en = 1'b0;
    tick();
    chk("dis_raw_req", 32'(raw_req), 32'd0);
    chk("dis_timeout_err", 32'(timeout_err), 32'd0);
    chk("dis_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (4) tick();
    sensor_hold = 1'b0;
    repeat (3) tick();
    sensor_en = 1'b1;
    tick();
    chk("reenable_req", 32'(raw_req), 32'd1);
    serve(1, 1'b0, 1'b0, $urandom());

    // asynchronous reset while waiting with data buffered
    sensor_hold = 1'b1;
    serve(0, 1'b0, 1'b0, $urandom());
    serve(0, 1'b0, 1'b0, $urandom());
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    sensor_hold = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    serve(2, 1'b0, 1'b0, $urandom());

    // randomized mix of delays, timeouts, holds and disables
    for (int i = 0; i < 150; i++) begin
      sensor_hold = ($urandom_range(0, 3) == 0);
      serve($urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), $urandom());
      if ($urandom_range(0, 19) == 0) begin
        sensor_en = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        sensor_en = 1'b1;
      end
    end

    // drop counter saturation
    sensor_en = 1'b0;
    tick();
    sensor_en = 1'b1;
    sensor_hold = 1'b1;
    for (int i = 0; i < 262; i++) serve(0, 1'b0, 1'b0, $urandom());
    chk("drop_saturated", 32'(drop_cnt), 32'd255);

    // drain and confirm every expected strobe appeared
    sensor_hold = 1'b0;
    repeat (20) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
